cpu_seq: RTL and testbench
==========================

CPU_SEQ -- requirements
Module: cpu_seq

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset.
- instruction  in  8  current instruction; opcode = instruction[7:6].
- mem_ready  in  1  data memory completion strobe.
- halt_req  in  1  request to pause at an instruction boundary.
- PCWrite  out  1  PC update enable.
- IRWrite  out  1  instruction register load.
- ALUSrc  out  1  ALU B operand = sign-extended immediate.
- MemRead  out  1  data memory read request.
- MemWrite  out  1  data memory write request.
- RegWrite  out  1  register file write.
- MemtoReg  out  1  writeback source = memory.
- Jump  out  1  PC source = jump target.
- state  out  3  current FSM state.
- halted  out  1  FSM in HALT.
- instr_count  out  8  retired-instruction counter.
- err  out  1  memory timeout flag, sticky.

Function
REQ-003 SHALL be a multi-cycle sequencer; control outputs SHALL be decoded from the state register and latched opcode only (Moore).
REQ-004 State encoding SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; 7 unused and SHALL go to IDLE.
REQ-005 Opcodes SHALL be 00 ALU, 01 LOAD, 10 STORE, 11 JUMP.
REQ-006 Paths SHALL be ALU: FETCH-DECODE-EXEC-WB; LOAD: FETCH-DECODE-EXEC-MEM-WB; STORE: FETCH-DECODE-EXEC-MEM; JUMP: FETCH-DECODE-EXEC.
REQ-007 Opcode SHALL be latched from instruction[7:6] on the DECODE-to-EXEC edge and held until the next DECODE.
REQ-008 FETCH SHALL assert IRWrite=1 and PCWrite=1 for exactly one cycle.
REQ-009 EXEC SHALL assert ALUSrc=1 for LOAD/STORE, and Jump=1 with PCWrite=1 for JUMP.
REQ-010 MEM SHALL hold MemRead=1 (LOAD) or MemWrite=1 (STORE) until the cycle mem_ready=1 is sampled, then leave on that edge; minimum MEM occupancy is 1 cycle.
REQ-011 WB SHALL assert RegWrite=1 for one cycle, with MemtoReg=1 for LOAD only.
REQ-012 Every control output not named for a state SHALL be 0 in that state.
REQ-013 Retire points are leaving WB, leaving MEM for STORE, and leaving EXEC for JUMP; at each, instr_count SHALL increment by 1 (wraps 255 to 0).
REQ-014 At each retire point and when leaving IDLE, next state SHALL be HALT if halt_req=1, else FETCH.
REQ-015 HALT SHALL set halted=1 and all controls 0, and SHALL go to FETCH on the first cycle halt_req=0 (with err=0).
REQ-016 halt_req SHALL be ignored away from instruction boundaries; an in-flight MEM request always completes first.
REQ-017 IDLE SHALL last exactly one cycle after reset release.

Reset
REQ-018 reset=0 SHALL immediately force state=IDLE, all control outputs 0, halted=0, instr_count=0, err=0, latched opcode=00, and clear the timeout counter, including mid-MEM.

Configuration
REQ-019 Macro CPU_SEQ_TIMEOUT_EN SHALL control the memory timeout.
- Defined: a 4-bit wait counter clears on MEM entry and increments each MEM cycle with mem_ready=0. If mem_ready=0 while the counter equals 15 (16th wait cycle), the next state SHALL be HALT with err=1. HALT with err=1 SHALL exit only via reset. The timed-out instruction does not retire.
- Undefined: MEM SHALL wait indefinitely; err SHALL be constant 0.

Verification
REQ-020 Reset release, halt_req=0, instruction=0x12 with mem_ready=1 -> state 0,1,2,3,5,1; RegWrite=1 only in WB; instr_count 0 to 1.
REQ-021 instruction=0x45 (LOAD), mem_ready rises 3 cycles after MEM entry -> MemRead=1 for 4 cycles; then WB with RegWrite=1 and MemtoReg=1.
REQ-022 instruction=0x85 (STORE) with mem_ready=1 -> MemWrite=1 for 1 cycle, no RegWrite; instruction=0xC5 (JUMP) -> Jump=1 and PCWrite=1 in EXEC, then FETCH.
REQ-023 halt_req=1 asserted during EXEC of an ALU instruction -> WB completes, state=6, halted=1; halt_req=0 -> FETCH next cycle.
REQ-024 reset=0 mid-MEM with MemRead=1 -> same-cycle MemRead=0, state=0, instr_count=0; after 256 ALU retires, instr_count=0.
REQ-025 With CPU_SEQ_TIMEOUT_EN and mem_ready held 0 -> 16 MEM cycles, then state=6 and err=1, held until reset; without the macro -> remains in MEM and err=0.

Source files
------------

// File: rtl/cpu_seq_if.sv
// Bus bundle between the multi-cycle sequencer and its datapath/memory.
// The master modport is the sequencer side; slave is the datapath/environment side.
interface cpu_seq_if;
  logic [7:0] instruction;
  logic       mem_ready;
  logic       halt_req;
  logic       PCWrite;
  logic       IRWrite;
  logic       ALUSrc;
  logic       MemRead;
  logic       MemWrite;
  logic       RegWrite;
  logic       MemtoReg;
  logic       Jump;
  logic [2:0] state;
  logic       halted;
  logic [7:0] instr_count;
  logic       err;

  modport master (
    input  instruction, mem_ready, halt_req,
    output PCWrite, IRWrite, ALUSrc, MemRead, MemWrite, RegWrite, MemtoReg, Jump,
    output state, halted, instr_count, err
  );

  modport slave (
    output instruction, mem_ready, halt_req,
    input  PCWrite, IRWrite, ALUSrc, MemRead, MemWrite, RegWrite, MemtoReg, Jump,
    input  state, halted, instr_count, err
  );
endinterface

// File: rtl/cpu_seq.sv
// Multi-cycle CPU control sequencer (Moore): FETCH/DECODE/EXEC/MEM/WB with halt support.
// Optional memory timeout enabled by defining CPU_SEQ_TIMEOUT_EN.
module cpu_seq (
  input  logic      clk,
  input  logic      reset,
  cpu_seq_if.master bus
);
  localparam int unsigned StateW = 3;
  localparam int unsigned OpW    = 2;
  localparam int unsigned CntW   = 8;

  localparam logic [OpW-1:0] OP_ALU   = 2'b00;
  localparam logic [OpW-1:0] OP_LOAD  = 2'b01;
  localparam logic [OpW-1:0] OP_STORE = 2'b10;
  localparam logic [OpW-1:0] OP_JUMP  = 2'b11;

  typedef enum logic [StateW-1:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [OpW-1:0]  opcode_q, opcode_d;
  logic [CntW-1:0] count_q, count_d;
  logic            retire;
  logic            err_c;

  logic pc_write_q, pc_write_d;
  logic ir_write_q, ir_write_d;
  logic alu_src_q, alu_src_d;
  logic mem_read_q, mem_read_d;
  logic mem_write_q, mem_write_d;
  logic reg_write_q, reg_write_d;
  logic mem_to_reg_q, mem_to_reg_d;
  logic jump_q, jump_d;
  logic halted_q, halted_d;

`ifdef CPU_SEQ_TIMEOUT_EN
  localparam int unsigned WaitW = 4;
  localparam logic [WaitW-1:0] WaitMax = '1;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             err_q, err_d;
  assign err_c = err_q;
`else
  assign err_c = 1'b0;
`endif

  // Only the opcode field of the instruction steers sequencing.
  logic instr_unused;
  assign instr_unused = ^bus.instruction[5:0];

  // Next-state, retire accounting and registered control decode of the next state.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    count_d  = count_q;
    retire   = 1'b0;
`ifdef CPU_SEQ_TIMEOUT_EN
    wait_d   = wait_q;
    err_d    = err_q;
`endif
    pc_write_d   = 1'b0;
    ir_write_d   = 1'b0;
    alu_src_d    = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    reg_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    jump_d       = 1'b0;
    halted_d     = 1'b0;

    case (state_q)
      IDLE:   state_d = bus.halt_req ? HALT : FETCH;
      FETCH:  state_d = DECODE;
      DECODE: begin
        state_d  = EXEC;
        opcode_d = bus.instruction[7:6];
      end
      EXEC: begin
        case (opcode_q)
          OP_ALU:  state_d = WB;
          OP_JUMP: retire  = 1'b1;
          default: state_d = MEM;
        endcase
`ifdef CPU_SEQ_TIMEOUT_EN
        wait_d = '0;
`endif
      end
      MEM: begin
        if (bus.mem_ready) begin
          if (opcode_q == OP_LOAD) state_d = WB;
          else                     retire  = 1'b1;
        end
`ifdef CPU_SEQ_TIMEOUT_EN
        else if (wait_q == WaitMax) begin
          // Timed-out access parks in HALT without retiring; only reset recovers.
          state_d = HALT;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 4'd1;
        end
`endif
      end
      WB:     retire = 1'b1;
      HALT:   if (!bus.halt_req && !err_c) state_d = FETCH;
      default: state_d = IDLE;
    endcase

    if (retire) begin
      state_d = bus.halt_req ? HALT : FETCH;
      count_d = count_q + 8'd1;
    end

    case (state_d)
      FETCH: begin
        pc_write_d = 1'b1;
        ir_write_d = 1'b1;
      end
      EXEC: begin
        alu_src_d  = (opcode_d == OP_LOAD) || (opcode_d == OP_STORE);
        jump_d     = (opcode_d == OP_JUMP);
        pc_write_d = (opcode_d == OP_JUMP);
      end
      MEM: begin
        mem_read_d  = (opcode_d == OP_LOAD);
        mem_write_d = (opcode_d == OP_STORE);
      end
      WB: begin
        reg_write_d  = 1'b1;
        mem_to_reg_d = (opcode_d == OP_LOAD);
      end
      HALT:    halted_d = 1'b1;
      default: ;
    endcase
  end

  // State and output registers; reset clears everything, including mid-access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      opcode_q     <= OP_ALU;
      count_q      <= '0;
      pc_write_q   <= 1'b0;
      ir_write_q   <= 1'b0;
      alu_src_q    <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      jump_q       <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      count_q      <= count_d;
      pc_write_q   <= pc_write_d;
      ir_write_q   <= ir_write_d;
      alu_src_q    <= alu_src_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      jump_q       <= jump_d;
      halted_q     <= halted_d;
    end
  end

`ifdef CPU_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end
`endif

  assign bus.PCWrite     = pc_write_q;
  assign bus.IRWrite     = ir_write_q;
  assign bus.ALUSrc      = alu_src_q;
  assign bus.MemRead     = mem_read_q;
  assign bus.MemWrite    = mem_write_q;
  assign bus.RegWrite    = reg_write_q;
  assign bus.MemtoReg    = mem_to_reg_q;
  assign bus.Jump        = jump_q;
  assign bus.state       = state_q;
  assign bus.halted      = halted_q;
  assign bus.instr_count = count_q;
  assign bus.err         = err_c;
endmodule

// File: tb/tb_cpu_seq.sv
// Self-checking bench for cpu_seq: directed scenarios plus randomized instruction
// streams checked cycle by cycle against a per-instruction path model.
module tb_cpu_seq;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_seq_if bus ();
  cpu_seq dut (.clk(clk), .reset(reset), .bus(bus));

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3,
                 S_MEM = 4, S_WB = 5, S_HALT = 6;

  int         vectors = 0;
  int         miscompares = 0;
  logic [1:0] op_model;
  logic [7:0] exp_count;
  logic       exp_err;

  // Expected controls per state: PCWrite IRWrite ALUSrc MemRead MemWrite RegWrite MemtoReg Jump halted
  function automatic logic [8:0] ref_ctrl(input int st, input logic [1:0] op);
    case (st)
      S_FETCH: return 9'b110000000;
      S_EXEC:  return (op == 2'd3) ? 9'b100000010 :
                      (op == 2'd1 || op == 2'd2) ? 9'b001000000 : 9'b0;
      S_MEM:   return (op == 2'd1) ? 9'b000100000 :
                      (op == 2'd2) ? 9'b000010000 : 9'b0;
      S_WB:    return {5'b0, 1'b1, (op == 2'd1), 2'b0};
      S_HALT:  return 9'b000000001;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic [8:0] obs_ctrl();
    return {bus.PCWrite, bus.IRWrite, bus.ALUSrc, bus.MemRead, bus.MemWrite,
            bus.RegWrite, bus.MemtoReg, bus.Jump, bus.halted};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic expect_cycle(input int st);
    chk("state", 32'(bus.state), 32'(st));
    chk("ctrl", 32'(obs_ctrl()), 32'(ref_ctrl(st, op_model)));
    chk("instr_count", 32'(bus.instr_count), 32'(exp_count));
    chk("err", 32'(bus.err), 32'(exp_err));
  endtask

  task automatic step(input logic hr);
    bus.halt_req = hr;
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick(input bit noisy, input logic dflt);
    return noisy ? 1'($urandom_range(0, 1)) : dflt;
  endfunction

  // One full instruction from FETCH to its retire edge; halt_req at retire is hr_final.
  task automatic run_instr(input logic [7:0] instr, input int lat, input logic hr_final,
                           input bit noisy);
    logic [1:0] op;
    op = instr[7:6];
    op_model = op;
    bus.instruction = instr;
    bus.mem_ready = 1'b0;
    expect_cycle(S_FETCH);  step(pick(noisy, 1'b0));
    expect_cycle(S_DECODE); step(pick(noisy, 1'b0));
    bus.instruction = 8'($urandom);
    expect_cycle(S_EXEC);
    if (op == 2'd3) begin
      exp_count++;
      step(hr_final);
    end else begin
      step(pick(noisy, hr_final));
      if (op != 2'd0) begin
        for (int i = 0; i <= lat; i++) begin
          bus.mem_ready = (i == lat);
          expect_cycle(S_MEM);
          if (op == 2'd2 && i == lat) begin
            exp_count++;
            step(hr_final);
          end else begin
            step(pick(noisy, hr_final));
          end
        end
        bus.mem_ready = 1'b0;
      end
      if (op != 2'd2) begin
        expect_cycle(S_WB);
        exp_count++;
        step(hr_final);
      end
    end
  endtask

  task automatic boundary(input logic hr, input int hold);
    if (hr) begin
      for (int k = 0; k <= hold; k++) begin
        expect_cycle(S_HALT);
        step(k == hold ? 1'b0 : 1'b1);
      end
    end
  endtask

  task automatic do_reset_release();
    @(negedge clk);
    reset = 1'b1;
    #1;
    expect_cycle(S_IDLE);
  endtask

  initial begin
    reset = 1'b1;
    bus.instruction = 8'h00;
    bus.mem_ready = 1'b0;
    bus.halt_req = 1'b0;
    exp_count = 8'd0;
    exp_err = 1'b0;
    op_model = 2'd0;
    #1 reset = 1'b0;
    #1 expect_cycle(S_IDLE);
    repeat (2) @(posedge clk);
    do_reset_release();
    step(1'b0);

    // Directed: ALU, LOAD with 3 wait cycles, STORE, JUMP, halt during ALU EXEC.
    run_instr(8'h12, 0, 1'b0, 1'b0);
    chk("alu_retire_count", 32'(bus.instr_count), 32'd1);
    run_instr(8'h45, 3, 1'b0, 1'b0);
    run_instr(8'h85, 0, 1'b0, 1'b0);
    run_instr(8'hC5, 0, 1'b0, 1'b0);
    run_instr(8'h12, 0, 1'b1, 1'b0);
    boundary(1'b1, 0);

    // Randomized stream with halt_req noise away from boundaries.
    for (int n = 0; n < 60; n++) begin
      logic hr;
      hr = ($urandom_range(0, 3) == 0);
      run_instr(8'($urandom), int'($urandom_range(0, 4)), hr, 1'b1);
      boundary(hr, int'($urandom_range(0, 2)));
    end
    expect_cycle(S_FETCH);

    // Reset in the middle of a LOAD memory access.
    op_model = 2'd1;
    bus.instruction = 8'h45;
    bus.mem_ready = 1'b0;
    step(1'b0); expect_cycle(S_DECODE);
    step(1'b0); expect_cycle(S_EXEC);
    step(1'b0); expect_cycle(S_MEM);
    reset = 1'b0;
    #1;
    exp_count = 8'd0;
    op_model = 2'd0;
    expect_cycle(S_IDLE);
    chk("reset_memread", 32'(bus.MemRead), 32'd0);
    do_reset_release();
    step(1'b1);
    expect_cycle(S_HALT);
    step(1'b0);

    // 256 retires wrap the counter back to zero.
    for (int n = 0; n < 256; n++) run_instr(8'($urandom) & 8'h3F, 0, 1'b0, 1'b1);
    chk("count_wrap", 32'(bus.instr_count), 32'd0);

    // Memory never answers.
    op_model = 2'd1;
    bus.instruction = 8'h40;
    bus.mem_ready = 1'b0;
    expect_cycle(S_FETCH);
    step(1'b0); expect_cycle(S_DECODE);
    step(1'b0); expect_cycle(S_EXEC);
    step(1'b0);
`ifdef CPU_SEQ_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      expect_cycle(S_MEM);
      step(1'b0);
    end
    exp_err = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_cycle(S_HALT);
      step(1'b0);
    end
`else
    for (int i = 0; i < 40; i++) begin
      expect_cycle(S_MEM);
      step(1'b0);
    end
`endif
    reset = 1'b0;
    #1;
    exp_err = 1'b0;
    exp_count = 8'd0;
    op_model = 2'd0;
    expect_cycle(S_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
